// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_stage
//  Description : Fetch stage plus IF/ID pipeline register. Holds the program
//                counter, captures the fetched instruction and its PC+4 into
//                IF/ID, and raises a combinational Stall when the instruction
//                in IF/ID depends on a load currently in EX, or when an
//                external freeze is requested. Flush squashes the fetch into
//                a bubble. A saturating counter tracks stall cycles.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk               in   1   rising-edge clock
//    reset             in   1   asynchronous active-high reset
//    PC_next           in  32   next fetch address from the PC-select mux
//    Instruction       in  32   instruction memory read data for PC
//    IF_ID_flush       in   1   squash the instruction fetched this cycle
//    stall_ext         in   1   external freeze request
//    MemRd_ID_EX       in   1   instruction in EX is a load
//    Rt_ID_EX          in   5   destination register of that load
//    PC                out 32   current fetch address
//    PC_IF_ID          out 32   PC+4 of the instruction held in IF/ID
//    Instruction_IF_ID out 32   instruction held in IF/ID
//    Valid_IF_ID       out  1   IF/ID holds a real instruction
//    Stall             out  1   combinational hazard / freeze stall
//    Stall_count       out 16   saturating count of stall cycles
// ----------------------------------------------------------------------------
//  Configuration
//    IF_ID_HAZARD_DETECT_EN : when defined, load-use hazard detection is
//                             built in. When undefined, Stall follows
//                             stall_ext only and MemRd_ID_EX / Rt_ID_EX are
//                             ignored (software inserts nops instead).
// ============================================================================
module if_id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_next,
  input  logic [31:0] Instruction,
  input  logic        IF_ID_flush,
  input  logic        stall_ext,
  input  logic        MemRd_ID_EX,
  input  logic [4:0]  Rt_ID_EX,
  output logic [31:0] PC,
  output logic [31:0] PC_IF_ID,
  output logic [31:0] Instruction_IF_ID,
  output logic        Valid_IF_ID,
  output logic        Stall,
  output logic [15:0] Stall_count
);

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] c_NOP      = 32'h0000_0000;
  localparam logic [31:0] c_PC_STEP  = 32'd4;
  localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

  logic [31:0] r_pc;
  logic [31:0] r_pc_if_id;
  logic [31:0] r_instr_if_id;
  logic        r_valid_if_id;
  logic [15:0] r_stall_count;

  logic [31:0] w_pc_plus4;
  logic        w_luh;
  logic        w_stall;

  // Natural 32-bit overflow gives the required wrap from FFFFFFFC to 0.
  assign w_pc_plus4 = r_pc + c_PC_STEP;

`ifdef IF_ID_HAZARD_DETECT_EN
  logic [4:0] w_rs_if_id;
  logic [4:0] w_rt_if_id;

  assign w_rs_if_id = r_instr_if_id[25:21];
  assign w_rt_if_id = r_instr_if_id[20:16];

  // A bubble never stalls, and a load to $zero carries no dependency.
  assign w_luh = MemRd_ID_EX & r_valid_if_id & (Rt_ID_EX != 5'd0) &
                 ((Rt_ID_EX == w_rs_if_id) | (Rt_ID_EX == w_rt_if_id));
`else
  // Hazard inputs are intentionally ignored in this build.
  logic w_unused_hazard_inputs;
  assign w_unused_hazard_inputs = ^{MemRd_ID_EX, Rt_ID_EX};
  assign w_luh = 1'b0;
`endif

  assign w_stall = w_luh | stall_ext;

  // Pipeline state: flush beats stall, so a squashed fetch still redirects
  // the PC even while a hazard is present.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= c_RESET_PC;
      r_pc_if_id    <= 32'h0000_0000;
      r_instr_if_id <= c_NOP;
      r_valid_if_id <= 1'b0;
    end else if (IF_ID_flush) begin
      r_pc          <= PC_next;
      r_pc_if_id    <= 32'h0000_0000;
      r_instr_if_id <= c_NOP;
      r_valid_if_id <= 1'b0;
    end else if (!w_stall) begin
      r_pc          <= PC_next;
      r_pc_if_id    <= w_pc_plus4;
      r_instr_if_id <= Instruction;
      r_valid_if_id <= 1'b1;
    end
  end

  // Counts every edge with Stall high, including flush edges; sticks at max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= 16'h0000;
    end else if (w_stall && (r_stall_count != c_CNT_MAX)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign PC                = r_pc;
  assign PC_IF_ID          = r_pc_if_id;
  assign Instruction_IF_ID = r_instr_if_id;
  assign Valid_IF_ID       = r_valid_if_id;
  assign Stall             = w_stall;
  assign Stall_count       = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_stage
//  Description : Directed self-checking bench for if_id_stage. The driver
//                applies inputs just after each rising edge and queues the
//                hand-computed outputs expected at the following falling
//                edge; an independent monitor pops and compares them there.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

`ifdef IF_ID_HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  localparam logic [31:0] c_DEP = 32'h00A6_3820; // add $7,$5,$6 : rs=5 rt=6

  logic        clk;
  logic        reset;
  logic [31:0] PC_next;
  logic [31:0] Instruction;
  logic        IF_ID_flush;
  logic        stall_ext;
  logic        MemRd_ID_EX;
  logic [4:0]  Rt_ID_EX;
  logic [31:0] PC;
  logic [31:0] PC_IF_ID;
  logic [31:0] Instruction_IF_ID;
  logic        Valid_IF_ID;
  logic        Stall;
  logic [15:0] Stall_count;

  if_id_stage dut (
    .clk               (clk),
    .reset             (reset),
    .PC_next           (PC_next),
    .Instruction       (Instruction),
    .IF_ID_flush       (IF_ID_flush),
    .stall_ext         (stall_ext),
    .MemRd_ID_EX       (MemRd_ID_EX),
    .Rt_ID_EX          (Rt_ID_EX),
    .PC                (PC),
    .PC_IF_ID          (PC_IF_ID),
    .Instruction_IF_ID (Instruction_IF_ID),
    .Valid_IF_ID       (Valid_IF_ID),
    .Stall             (Stall),
    .Stall_count       (Stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] pc_if_id;
    logic [31:0] instr;
    logic        valid;
    logic        stall;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Counts of stall edges accumulated at various points of the sequence.
  localparam logic [15:0] c_C1 = HZ ? 16'd1 : 16'd0;
  localparam logic [15:0] c_C2 = HZ ? 16'd2 : 16'd0;

  function automatic void push_exp(input string nm, input logic [31:0] e_pc,
                                   input logic [31:0] e_pcid, input logic [31:0] e_ins,
                                   input logic e_v, input logic e_st, input logic [15:0] e_cnt);
    exp_t e;
    e.name = nm; e.pc = e_pc; e.pc_if_id = e_pcid; e.instr = e_ins;
    e.valid = e_v; e.stall = e_st; e.cnt = e_cnt;
    exp_q.push_back(e);
  endfunction

  task automatic set_in(input logic [31:0] pn, input logic [31:0] ins, input logic fl,
                        input logic se, input logic mr, input logic [4:0] rt);
    PC_next = pn; Instruction = ins; IF_ID_flush = fl;
    stall_ext = se; MemRd_ID_EX = mr; Rt_ID_EX = rt;
  endtask

  // One cycle: apply inputs, queue the outputs expected before the next edge.
  task automatic step(input string nm, input logic [31:0] pn, input logic [31:0] ins,
                      input logic fl, input logic se, input logic mr, input logic [4:0] rt,
                      input logic [31:0] e_pc, input logic [31:0] e_pcid,
                      input logic [31:0] e_ins, input logic e_v, input logic e_st,
                      input logic [15:0] e_cnt);
    set_in(pn, ins, fl, se, mr, rt);
    push_exp(nm, e_pc, e_pcid, e_ins, e_v, e_st, e_cnt);
    @(posedge clk); #1;
  endtask

  // Monitor: compare every queued expectation at the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (PC !== e.pc || PC_IF_ID !== e.pc_if_id || Instruction_IF_ID !== e.instr ||
          Valid_IF_ID !== e.valid || Stall !== e.stall || Stall_count !== e.cnt) begin
        errors++;
        $display("FAIL %s: got PC=%h PC_IF_ID=%h Instr=%h V=%b Stall=%b Cnt=%h ; expected PC=%h PC_IF_ID=%h Instr=%h V=%b Stall=%b Cnt=%h",
                 e.name, PC, PC_IF_ID, Instruction_IF_ID, Valid_IF_ID, Stall, Stall_count,
                 e.pc, e.pc_if_id, e.instr, e.valid, e.stall, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    step("reset_hold", 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0, 16'h0);
    reset = 1'b0;

    // Sequential fetch, PC_next = PC+4 and Instruction = PC.
    step("seq0", 32'd4,  32'd0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0, 16'h0);
    step("seq1", 32'd8,  32'd4, 0, 0, 0, 5'd0, 32'd4, 32'd4, 32'd0, 1, 0, 16'h0);
    step("seq2", 32'd12, 32'd8, 0, 0, 0, 5'd0, 32'd8, 32'd8, 32'd4, 1, 0, 16'h0);
    step("seq3", 32'd16, c_DEP, 0, 0, 0, 5'd0, 32'd12, 32'd12, 32'd8, 1, 0, 16'h0);

    // Load to $5 in EX while IF/ID reads $5.
    step("luh_rs", 32'd20, 32'h1111_1111, 0, 0, 1, 5'd5,
         32'd16, 32'd16, c_DEP, 1, HZ, 16'h0);
    step("luh_after", 32'd24, 32'h2222_2222, 0, 0, 0, 5'd0,
         HZ ? 32'd16 : 32'd20, HZ ? 32'd16 : 32'd20, HZ ? c_DEP : 32'h1111_1111, 1, 0, c_C1);
    step("rt0_a", 32'd28, 32'h0, 0, 0, 1, 5'd0,
         32'd24, HZ ? 32'd20 : 32'd24, 32'h2222_2222, 1, 0, c_C1);
    step("rt0_b", 32'd32, 32'h0, 0, 0, 1, 5'd0, 32'd28, 32'd28, 32'h0, 1, 0, c_C1);
    step("load_dep", 32'd36, c_DEP, 0, 0, 0, 5'd0, 32'd32, 32'd32, 32'h0, 1, 0, c_C1);

    // Flush together with a hazard on rt=6.
    step("flush_luh", 32'h100, 32'h3333_3333, 1, 0, 1, 5'd6,
         32'd36, 32'd36, c_DEP, 1, HZ, c_C1);
    step("bubble", 32'h104, 32'h4444_4444, 0, 0, 1, 5'd6,
         32'h100, 32'h0, 32'h0, 0, 0, c_C2);

    // External freeze for 70000 cycles; counter must saturate.
    set_in(32'h200, 32'h5555_5555, 1'b0, 1'b1, 1'b0, 5'd0);
    for (int k = 0; k < 70000; k++) begin
      if (k == 0 || k == 1 || k == 65533 || k == 65534 || k == 65535 || k == 65536 || k == 69999) begin
        int unsigned cv;
        cv = c_C2 + k;
        if (cv > 32'hFFFF) cv = 32'hFFFF;
        push_exp($sformatf("freeze_%0d", k), 32'h104, 32'h104, 32'h4444_4444, 1, 1, cv[15:0]);
      end
      @(posedge clk); #1;
    end

    step("resume", 32'h200, 32'h5555_5555, 0, 0, 0, 5'd0,
         32'h104, 32'h104, 32'h4444_4444, 1, 0, 16'hFFFF);
    step("after_resume", 32'hFFFF_FFFC, 32'h6666_6666, 0, 0, 0, 5'd0,
         32'h200, 32'h108, 32'h5555_5555, 1, 0, 16'hFFFF);
    step("fetch_top", 32'h0, 32'h7777_7777, 0, 0, 0, 5'd0,
         32'hFFFF_FFFC, 32'h204, 32'h6666_6666, 1, 0, 16'hFFFF);
    step("wrap", 32'd4, 32'h8888_8888, 0, 0, 0, 5'd0,
         32'h0, 32'h0, 32'h7777_7777, 1, 0, 16'hFFFF);

    // Asynchronous reset asserted mid-cycle while frozen.
    set_in(32'd4, 32'h9999_9999, 1'b0, 1'b1, 1'b0, 5'd0);
    reset = 1'b1;
    #1;
    push_exp("async_reset", 32'h0, 32'h0, 32'h0, 0, 1, 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    step("post_reset", 32'd4, 32'h9999_9999, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0, 16'h0);
    step("first_fetch", 32'd8, 32'h0, 0, 0, 0, 5'd0,
         32'd4, 32'd4, 32'h9999_9999, 1, 0, 16'h0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for every register in the block.
REQ-003 reset  input  1  asynchronous, active-high reset; clears all state while high.
REQ-004 PC_next  input  32  next fetch address from the PC-select mux.
REQ-005 Instruction  input  32  instruction-memory read data for the current PC (combinational).
REQ-006 IF_ID_flush  input  1  squash the instruction being fetched this cycle (taken branch, jump or exception).
REQ-007 stall_ext  input  1  external freeze request (e.g. data-memory wait).
REQ-008 MemRd_ID_EX  input  1  the instruction in EX is a load.
REQ-009 Rt_ID_EX  input  5  destination register of that load.
REQ-010 PC  output  32  current fetch address.
REQ-011 PC_IF_ID  output  32  PC+4 of the instruction held in IF/ID.
REQ-012 Instruction_IF_ID  output  32  instruction held in IF/ID.
REQ-013 Valid_IF_ID  output  1  IF/ID holds a real instruction, not a bubble.
REQ-014 Stall  output  1  combinational hazard stall; downstream uses it to force ID_EX_flush.
REQ-015 Stall_count  output  16  saturating count of stall cycles.

Function
REQ-016 PC+4 SHALL be computed modulo 2^32, with wrap from 32'hFFFFFFFC to 0.
REQ-017 Load-use hazard (luh) SHALL be: MemRd_ID_EX & Valid_IF_ID & Rt_ID_EX!=0 & (Rt_ID_EX==Instruction_IF_ID[25:21] | Rt_ID_EX==Instruction_IF_ID[20:16]).
REQ-018 Stall SHALL equal luh | stall_ext, combinationally, with no added latency.
REQ-019 Priority at each rising edge SHALL be reset > IF_ID_flush > Stall > normal.
REQ-020 Normal operation:
- PC<=PC_next.
- PC_IF_ID<=PC+4.
- Instruction_IF_ID<=Instruction.
- Valid_IF_ID<=1.
REQ-021 Stall without flush: PC, PC_IF_ID, Instruction_IF_ID and Valid_IF_ID SHALL all hold their values.
REQ-022 Flush (whether or not Stall is also asserted):
- PC<=PC_next.
- Instruction_IF_ID<=32'h00000000 (nop).
- PC_IF_ID<=0.
- Valid_IF_ID<=0.
REQ-023 Stall_count SHALL increment by one on every edge where Stall=1, and SHALL saturate at 16'hFFFF (no wrap).
REQ-024 Fetch-to-IF/ID latency SHALL be one cycle; a luh stall SHALL last exactly one cycle for a single load-use pair.
REQ-025 A bubble (Valid_IF_ID=0) SHALL never raise luh.
REQ-026 Stall_ext held for N cycles SHALL freeze the state for N cycles; the sequence SHALL resume unchanged on the cycle after release.

Reset
REQ-027 While reset=1 the block SHALL hold:
- PC=32'h00000000.
- PC_IF_ID=0.
- Instruction_IF_ID=0.
- Valid_IF_ID=0.
- Stall_count=0.
REQ-028 A reset asserted mid-stall or mid-flush SHALL take effect immediately, without waiting for clk.
REQ-029 The first edge after reset deassertion SHALL perform a normal fetch of address 0.

Configuration
REQ-030 With macro IF_ID_HAZARD_DETECT_EN defined, luh SHALL be computed per REQ-017.
REQ-031 With IF_ID_HAZARD_DETECT_EN undefined:
- luh SHALL be constant 0, so Stall=stall_ext.
- MemRd_ID_EX and Rt_ID_EX SHALL be unused.
- Load-use hazards SHALL be left to software nops.

Verification
REQ-032 Reset release with PC_next=PC+4 and Instruction=PC -> after 3 edges PC=12, PC_IF_ID=12, Instruction_IF_ID=8, Valid_IF_ID=1.
REQ-033 Instruction_IF_ID=lw-dependent instruction with rs=5, MemRd_ID_EX=1, Rt_ID_EX=5 -> Stall=1 in the same cycle; PC and IF/ID unchanged for one edge; Stall_count=1; Rt_ID_EX=0 case -> Stall=0.
REQ-034 IF_ID_flush=1 together with luh=1 and PC_next=32'h100 -> PC=32'h100, Instruction_IF_ID=0, Valid_IF_ID=0, and Stall=0 on the next cycle.
REQ-035 stall_ext held 70000 cycles -> Stall_count=16'hFFFF with no wrap; state frozen throughout; normal fetch resumes on the first edge after release.
REQ-036 PC=32'hFFFFFFFC fetched -> PC_IF_ID=0; reset pulsed between edges -> all outputs zero immediately.
REQ-037 Build without IF_ID_HAZARD_DETECT_EN using the stimulus of REQ-033 -> Stall=0 and the pipeline advances.
